// File: rtl/pal_config_sequencer_pkg.sv
// Shared types and constants for the PAL configuration sequencer: FSM state
// encoding, default geometry and the literal-width helper.
package pal_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD_AND = 2'd1,
    LOAD_OR  = 2'd2,
    ARMED    = 2'd3
  } pal_state_e;

  localparam int DEF_NUM_INPUTS  = 5;
  localparam int DEF_NUM_TERMS   = 8;
  localparam int DEF_NUM_OUTPUTS = 4;

  // Every input contributes a true and a complemented literal.
  function automatic int lit_width(input int num_inputs);
    return 2 * num_inputs;
  endfunction

endpackage

// File: rtl/pal_config_sequencer_if.sv
// Configuration handshake and evaluation bus of the PAL sequencer; the master
// side loads fuse rows and issues evaluation requests, the slave is the array.
interface pal_config_sequencer_if
  import pal_pkg::*;
#(
  parameter int NUM_INPUTS  = DEF_NUM_INPUTS,
  parameter int NUM_TERMS   = DEF_NUM_TERMS,
  parameter int NUM_OUTPUTS = DEF_NUM_OUTPUTS
);

  localparam int L = lit_width(NUM_INPUTS);

  logic                   cfg_start;
  logic                   cfg_valid;
  logic [L-1:0]           cfg_data;
  logic                   cfg_ready;
  logic                   cfg_done;
  logic                   cfg_err;
  logic                   busy;
  logic                   in_valid;
  logic [NUM_INPUTS-1:0]  in_data;
  logic                   out_valid;
  logic [NUM_OUTPUTS-1:0] out_data;

  modport master (
    output cfg_start, cfg_valid, cfg_data, in_valid, in_data,
    input  cfg_ready, cfg_done, cfg_err, busy, out_valid, out_data
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_data, in_valid, in_data,
    output cfg_ready, cfg_done, cfg_err, busy, out_valid, out_data
  );

endinterface

// File: rtl/pal_literal_expander.sv
// Expands the PAL input vector into its literal vector: literal 2i is the
// input bit itself, literal 2i+1 its complement.
module pal_literal_expander #(
  parameter int NUM_INPUTS = 5
) (
  input  logic [NUM_INPUTS-1:0]   in_data,
  output logic [2*NUM_INPUTS-1:0] lits
);

  always_comb begin
    lits = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      lits[2*i]   = in_data[i];
      lits[2*i+1] = ~in_data[i];
    end
  end

endmodule

// File: rtl/pal_config_sequencer.sv
// Programmable AND/OR array with a streamed fuse-map loader: AND rows then OR
// rows are written over a valid/ready handshake, after which the array evaluates.
module pal_config_sequencer
  import pal_pkg::*;
#(
  parameter int NUM_INPUTS  = DEF_NUM_INPUTS,
  parameter int NUM_TERMS   = DEF_NUM_TERMS,
  parameter int NUM_OUTPUTS = DEF_NUM_OUTPUTS
) (
  input logic                  clk,
  input logic                  rst_n,
  pal_config_sequencer_if.slave bus
);

  localparam int L       = lit_width(NUM_INPUTS);
  localparam int CNT_MAX = (NUM_TERMS > NUM_OUTPUTS) ? NUM_TERMS : NUM_OUTPUTS;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  pal_state_e             state;
  logic [CW-1:0]          row_cnt;
  logic [L-1:0]           and_fuse [NUM_TERMS];
  logic [NUM_TERMS-1:0]   or_fuse  [NUM_OUTPUTS];
  logic                   cfg_err_q;
  logic                   out_valid_q;
  logic [NUM_OUTPUTS-1:0] out_data_q;

  logic [L-1:0]           lits;
  logic [NUM_TERMS-1:0]   terms;
  logic [NUM_OUTPUTS-1:0] eval_out;
  logic [L-1:0]           or_spill;
  logic                   loading;
  logic                   xfer;

  pal_literal_expander #(.NUM_INPUTS(NUM_INPUTS)) u_expander (
    .in_data (bus.in_data),
    .lits    (lits)
  );

  assign loading  = (state == LOAD_AND) || (state == LOAD_OR);
  assign xfer     = bus.cfg_valid && loading && !bus.cfg_start;
  assign or_spill = bus.cfg_data >> NUM_TERMS;

  // An unprogrammed AND fuse passes 1; an unprogrammed OR fuse contributes 0.
  always_comb begin
    terms = '0;
    for (int t = 0; t < NUM_TERMS; t++) begin
      terms[t] = &(~and_fuse[t] | lits);
    end
  end

  always_comb begin
    eval_out = '0;
    for (int o = 0; o < NUM_OUTPUTS; o++) begin
      eval_out[o] = |(or_fuse[o] & terms);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      row_cnt     <= '0;
      cfg_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int t = 0; t < NUM_TERMS; t++) and_fuse[t] <= '0;
      for (int o = 0; o < NUM_OUTPUTS; o++) or_fuse[o] <= '0;
    end else begin
      out_valid_q <= 1'b0;
      if (bus.cfg_start) begin
        state     <= LOAD_AND;
        row_cnt   <= '0;
        cfg_err_q <= 1'b0;
      end else begin
        case (state)
          LOAD_AND: begin
            if (xfer) begin
              for (int t = 0; t < NUM_TERMS; t++) begin
                if (row_cnt == CW'(t)) and_fuse[t] <= bus.cfg_data;
              end
              if (row_cnt == CW'(NUM_TERMS - 1)) begin
                row_cnt <= '0;
                state   <= LOAD_OR;
              end else begin
                row_cnt <= row_cnt + 1'b1;
              end
            end
          end
          LOAD_OR: begin
            if (xfer) begin
              for (int o = 0; o < NUM_OUTPUTS; o++) begin
                if (row_cnt == CW'(o)) or_fuse[o] <= bus.cfg_data[NUM_TERMS-1:0];
              end
              // Bits beyond the term count are dropped but flagged sticky.
              if (|or_spill) cfg_err_q <= 1'b1;
              if (row_cnt == CW'(NUM_OUTPUTS - 1)) begin
                row_cnt <= '0;
                state   <= ARMED;
              end else begin
                row_cnt <= row_cnt + 1'b1;
              end
            end
          end
          ARMED: begin
            if (bus.in_valid) begin
              out_valid_q <= 1'b1;
              out_data_q  <= eval_out;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.cfg_ready = loading;
  assign bus.busy      = loading;
  assign bus.cfg_done  = (state == ARMED);
  assign bus.cfg_err   = cfg_err_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_pal_config_sequencer.sv
// Directed bench for the PAL sequencer: loads fuse maps with hand-worked
// expected outputs and checks handshake, error, reset and restart behaviour.
module tb_pal_config_sequencer;
  import pal_pkg::*;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic [9:0] and_rows [8];
  logic [9:0] or_rows  [4];

  pal_config_sequencer_if #(.NUM_INPUTS(5), .NUM_TERMS(8), .NUM_OUTPUTS(4)) bus ();

  pal_config_sequencer #(.NUM_INPUTS(5), .NUM_TERMS(8), .NUM_OUTPUTS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [9:0] row);
    bus.cfg_valid = 1'b1;
    bus.cfg_data  = row;
    tick();
    bus.cfg_valid = 1'b0;
    bus.cfg_data  = '0;
  endtask

  task automatic startLoad();
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
  endtask

  task automatic loadMap();
    startLoad();
    for (int i = 0; i < 8; i++) applyStimulus(and_rows[i]);
    for (int i = 0; i < 4; i++) applyStimulus(or_rows[i]);
  endtask

  task automatic evaluate(input string tag, input logic [4:0] vec, input logic [3:0] expected);
    bus.in_valid = 1'b1;
    bus.in_data  = vec;
    tick();
    bus.in_valid = 1'b0;
    checkOutput({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    checkOutput({tag, "_data"}, 32'(bus.out_data), 32'(expected));
  endtask

  task automatic setBasicMap();
    and_rows[0] = 10'h005;
    for (int i = 1; i < 8; i++) and_rows[i] = 10'h000;
    or_rows[0] = 10'h001;
    or_rows[1] = 10'h002;
    or_rows[2] = 10'h000;
    or_rows[3] = 10'h001;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.cfg_start = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_data  = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    repeat (3) tick();

    checkOutput("rst_ready", 32'(bus.cfg_ready), 32'd0);
    checkOutput("rst_done", 32'(bus.cfg_done), 32'd0);
    checkOutput("rst_err", 32'(bus.cfg_err), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(bus.out_data), 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic load: term0 = in[0] & in[1], terms 1..7 constant 1.
    setBasicMap();
    startLoad();
    checkOutput("basic_busy", 32'(bus.busy), 32'd1);
    checkOutput("basic_ready", 32'(bus.cfg_ready), 32'd1);
    for (int i = 0; i < 8; i++) applyStimulus(and_rows[i]);
    for (int i = 0; i < 3; i++) applyStimulus(or_rows[i]);
    checkOutput("basic_done_early", 32'(bus.cfg_done), 32'd0);
    applyStimulus(or_rows[3]);
    checkOutput("basic_done", 32'(bus.cfg_done), 32'd1);
    checkOutput("basic_busy_after", 32'(bus.busy), 32'd0);
    evaluate("basic_00011", 5'b00011, 4'b1011);
    evaluate("basic_00001", 5'b00001, 4'b0010);
    tick();
    checkOutput("hold_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("hold_data", 32'(bus.out_data), 32'b0010);

    // Back-to-back requests, one result per cycle.
    bus.in_valid = 1'b1;
    bus.in_data  = 5'b00011;
    tick();
    checkOutput("b2b_first", 32'(bus.out_data), 32'b1011);
    bus.in_data  = 5'b10000;
    tick();
    bus.in_valid = 1'b0;
    checkOutput("b2b_second_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("b2b_second", 32'(bus.out_data), 32'b0010);

    // Backpressure: bubbles carry junk that must never be written.
    startLoad();
    for (int i = 0; i < 12; i++) begin
      bus.cfg_valid = 1'b0;
      bus.cfg_data  = 10'h3FF;
      tick();
      checkOutput("bp_busy_bubble", 32'(bus.busy), 32'd1);
      checkOutput("bp_cnt_bubble", 32'(dut.row_cnt), (i < 8) ? 32'(i) : 32'(i - 8));
      if (i < 8) applyStimulus(and_rows[i]);
      else applyStimulus(or_rows[i-8]);
      if (i < 11) begin
        checkOutput("bp_busy_xfer", 32'(bus.busy), 32'd1);
        checkOutput("bp_done_early", 32'(bus.cfg_done), 32'd0);
        checkOutput("bp_cnt_xfer", 32'(dut.row_cnt), (i < 8) ? 32'((i + 1) % 8) : 32'(i - 7));
      end
    end
    checkOutput("bp_done", 32'(bus.cfg_done), 32'd1);
    evaluate("bp_00011", 5'b00011, 4'b1011);
    evaluate("bp_00010", 5'b00010, 4'b0010);

    // Contradictory fuse: in[0] & ~in[0] is always 0.
    and_rows[0] = 10'h003;
    or_rows[0]  = 10'h001;
    or_rows[1]  = 10'h000;
    or_rows[3]  = 10'h000;
    loadMap();
    for (int v = 0; v < 32; v++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 5'(v);
      tick();
      checkOutput("contra_out0", 32'(bus.out_data[0]), 32'd0);
    end
    bus.in_valid = 1'b0;

    // Malformed OR row: upper bits flag an error and are dropped.
    setBasicMap();
    or_rows[1] = 10'h300;
    startLoad();
    for (int i = 0; i < 8; i++) applyStimulus(and_rows[i]);
    applyStimulus(or_rows[0]);
    checkOutput("err_before", 32'(bus.cfg_err), 32'd0);
    applyStimulus(or_rows[1]);
    checkOutput("err_set", 32'(bus.cfg_err), 32'd1);
    applyStimulus(or_rows[2]);
    applyStimulus(or_rows[3]);
    checkOutput("err_done", 32'(bus.cfg_done), 32'd1);
    checkOutput("err_sticky", 32'(bus.cfg_err), 32'd1);
    checkOutput("err_row1", 32'(dut.or_fuse[1]), 32'h00);
    evaluate("err_eval", 5'b00011, 4'b1001);
    startLoad();
    checkOutput("err_cleared", 32'(bus.cfg_err), 32'd0);

    // Reset mid-load after three AND rows.
    applyStimulus(10'h005);
    applyStimulus(10'h3FF);
    applyStimulus(10'h155);
    rst_n = 1'b0;
    #2;
    checkOutput("mid_rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("mid_rst_done", 32'(bus.cfg_done), 32'd0);
    checkOutput("mid_rst_out", 32'(bus.out_data), 32'd0);
    checkOutput("mid_rst_and1", 32'(dut.and_fuse[1]), 32'd0);
    checkOutput("mid_rst_or0", 32'(dut.or_fuse[0]), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    bus.cfg_valid = 1'b1;
    bus.cfg_data  = 10'h005;
    bus.in_valid  = 1'b1;
    bus.in_data   = 5'b00011;
    tick();
    bus.cfg_valid = 1'b0;
    bus.in_valid  = 1'b0;
    checkOutput("idle_no_out", 32'(bus.out_valid), 32'd0);
    checkOutput("idle_busy", 32'(bus.busy), 32'd0);
    checkOutput("idle_and0", 32'(dut.and_fuse[0]), 32'd0);
    setBasicMap();
    loadMap();
    evaluate("reload_00011", 5'b00011, 4'b1011);

    // Restart while armed with a coincident evaluation request.
    bus.cfg_start = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 5'b00011;
    tick();
    bus.cfg_start = 1'b0;
    bus.in_valid  = 1'b0;
    checkOutput("restart_no_out", 32'(bus.out_valid), 32'd0);
    checkOutput("restart_done", 32'(bus.cfg_done), 32'd0);
    checkOutput("restart_state", 32'(dut.state), 32'(LOAD_AND));
    checkOutput("restart_busy", 32'(bus.busy), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pal_config_sequencer.md
PAL_CONFIG_SEQUENCER -- requirements
Module: pal_config_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_INPUTS, default 5, giving the number of PAL inputs; the literal width is L = 2*NUM_INPUTS.
REQ-002 The block SHALL have parameter NUM_TERMS, default 8, giving the number of product terms; NUM_TERMS <= L is required.
REQ-003 The block SHALL have parameter NUM_OUTPUTS, default 4, giving the number of OR outputs.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  clock; all state changes on the rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 cfg_start  in  1  single-cycle pulse that begins a fuse-map load.
REQ-008 cfg_valid  in  1  cfg_data is valid.
REQ-009 cfg_data  in  L  one fuse row.
REQ-010 cfg_ready  out  1  block accepts a fuse row.
REQ-011 cfg_done  out  1  full fuse map loaded; array armed.
REQ-012 cfg_err  out  1  sticky flag for a malformed OR row.
REQ-013 busy  out  1  load in progress.
REQ-014 in_valid  in  1  evaluation request.
REQ-015 in_data  in  NUM_INPUTS  PAL input vector.
REQ-016 out_valid  out  1  out_data is valid this cycle.
REQ-017 out_data  out  NUM_OUTPUTS  evaluated PAL outputs.

Function
REQ-018 The FSM SHALL have states IDLE, LOAD_AND, LOAD_OR and ARMED.
REQ-019 cfg_start in any state SHALL move the FSM to LOAD_AND, zero the row counter, and clear cfg_done and cfg_err. Fuse contents are retained until overwritten.
REQ-020 cfg_ready and busy SHALL be 1 exactly in LOAD_AND and LOAD_OR. A transfer occurs only when cfg_valid and cfg_ready are both 1 and cfg_start is 0.
REQ-021 In LOAD_AND, transfer k SHALL write AND fuse row k, for k = 0..NUM_TERMS-1. After row NUM_TERMS-1, the counter wraps to 0 and the FSM enters LOAD_OR.
REQ-022 In LOAD_OR, transfer k SHALL write cfg_data[NUM_TERMS-1:0] to OR fuse row k. After row NUM_OUTPUTS-1, the FSM enters ARMED.
REQ-023 cfg_done SHALL be 1 exactly in ARMED; it rises in the cycle after the final OR transfer.
REQ-024 An OR-row transfer with any cfg_data bit >= NUM_TERMS set SHALL set cfg_err, which holds until the next cfg_start or reset. The masked row is still stored and the load continues.
REQ-025 Literal ordering SHALL be: literal 2i = in_data[i] and literal 2i+1 = ~in_data[i].
REQ-026 Term t SHALL be the AND over j of (andfuse[t][j] ? literal j : 1). An all-zero row therefore gives 1, and a row with both polarities of one input gives 0.
REQ-027 Output o SHALL be the OR over t of (orfuse[o][t] ? term t : 0). An all-zero row therefore gives 0.
REQ-028 In ARMED, in_valid=1 SHALL produce out_valid=1 and the registered out_data exactly one cycle later. Back-to-back requests are accepted every cycle.
REQ-029 in_valid outside ARMED, or coincident with cfg_start, SHALL be ignored and produce no out_valid.
REQ-030 out_data SHALL hold its last value while out_valid=0.

Reset
REQ-031 While rst_n=0, the FSM SHALL be IDLE, counters 0, all fuses 0, and all outputs 0.
REQ-032 Reset mid-load SHALL abort the load and discard partial fuse rows. After release, only cfg_start leaves IDLE.

Structure
REQ-033 Package pal_pkg SHALL hold the FSM state enum, the default parameter values, and the literal-width constant function.
REQ-034 Literal expansion SHALL be one sub-module, pal_literal_expander (NUM_INPUTS in, L out, combinational), instantiated once.
REQ-035 Fuse storage SHALL be flat registers: NUM_TERMS x L AND fuses and NUM_OUTPUTS x NUM_TERMS OR fuses. No memory macro is used.

Verification
REQ-036 The bench SHALL cover a basic load and evaluation: AND rows {0x005, then 0x000 x7}, OR rows {0x01, 0x02, 0x00, 0x01}. Then in_data=5'b00011 -> out_data=4'b1011 one cycle later, and in_data=5'b00001 -> 4'b0010.
REQ-037 The bench SHALL cover backpressure: cfg_valid toggling 1/0 over 12 rows -> counter advances only on transfers, cfg_done rises the cycle after the 12th transfer, and busy=1 throughout the load.
REQ-038 The bench SHALL cover a contradictory fuse: AND row0=0x003 with OR row0=0x01 -> out_data[0]=0 for all 32 in_data values.
REQ-039 The bench SHALL cover a malformed OR row: OR row1=0x300 -> cfg_err=1, row stored as 0x00, load completes, cfg_err cleared by the next cfg_start.
REQ-040 The bench SHALL cover reset mid-load: rst_n low after 3 AND rows -> all outputs 0, fuses 0, and in_valid ignored until a fresh full load.
REQ-041 The bench SHALL cover restart while ARMED: cfg_start together with in_valid -> no out_valid, cfg_done=0 next cycle, FSM in LOAD_AND.
